// File: rtl/pulpemu_rst_gen.sv
// pulpemu_rst_gen: board reset generator for the PULP emulator SoC.
// in: clk_i, rst_ni, btn_reset_i, jtag_trst_ni, clk_locked_i
// out: rst_no (SoC reset), rst_cause_o, rst_events_o
module pulpemu_rst_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES     = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_reset_i,
  input  logic       jtag_trst_ni,
  input  logic       clk_locked_i,
  output logic       rst_no,
  output logic [1:0] rst_cause_o,
  output logic [7:0] rst_events_o
);

  localparam logic [15:0] DB_MAX =
    16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] HOLD_MAX =
    16'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET     = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  logic        rst_int_n;
  logic [1:0]  btn_ff;
  logic [1:0]  trst_ff;
  logic [1:0]  lock_ff;
  logic        btn_sync;
  logic        trst_sync;
  logic        lock_sync;
  logic        btn_db;
  logic [15:0] db_cnt;
  logic        req;
  state_e      state_q;
  state_e      state_d;
  logic [15:0] hold_cnt_q;
  logic [15:0] hold_cnt_d;
  logic        take_req;
  logic [1:0]  cause_d;
  logic [7:0]  events_d;
  logic        rst_n_q;
  logic [1:0]  cause_q;
  logic [7:0]  events_q;

  // Deassertion retimed to clk_i; assertion
  // still reaches every flop asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_int_n <= 1'b0;
    end else begin
      rst_int_n <= 1'b1;
    end
  end

  // Request synchronizers run on the raw reset
  // so they are primed by the time the FSM
  // leaves RESET.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_ff  <= '0;
      trst_ff <= '0;
      lock_ff <= '0;
    end else begin
      btn_ff  <= {btn_ff[0], btn_reset_i};
      trst_ff <= {trst_ff[0], jtag_trst_ni};
      lock_ff <= {lock_ff[0], clk_locked_i};
    end
  end

  assign btn_sync  = btn_ff[1];
  assign trst_sync = trst_ff[1];
  assign lock_sync = lock_ff[1];

  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_sync != btn_db) begin
      if (db_cnt == DB_MAX) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign req = btn_db | ~trst_sync | ~lock_sync;

  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= RESET;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      RESET: begin
        state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!req) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (req) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_MAX) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      RUN: begin
        if (req) begin
          state_d = WAIT_LOCK;
        end
      end
      default: begin
        state_d = RESET;
      end
    endcase
  end

  // Only requests that break RUN are logged;
  // JTAG wins over button over lock loss.
  always_comb begin
    take_req = (state_q == RUN) && req;
    cause_d  = cause_q;
    events_d = events_q;
    if (!trst_sync) begin
      cause_d = 2'b10;
    end else if (btn_db) begin
      cause_d = 2'b01;
    end else begin
      cause_d = 2'b11;
    end
    if (events_q != 8'hFF) begin
      events_d = events_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rst_n_q  <= 1'b0;
      cause_q  <= 2'b00;
      events_q <= 8'd0;
    end else begin
      rst_n_q <= (state_d == RUN);
      if (take_req) begin
        cause_q  <= cause_d;
        events_q <= events_d;
      end
    end
  end

  assign rst_no       = rst_n_q;
  assign rst_cause_o  = cause_q;
  assign rst_events_o = events_q;

endmodule

// File: doc/pulpemu_rst_gen.md
PULPEMU_RST_GEN -- requirements
Module: pulpemu_rst_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1024: consecutive stable cycles before the debounced button changes; legal range 2..65535.
REQ-002 SHALL have parameter HOLD_CYCLES, default 256: minimum cycles the SoC reset is held after all requests clear; legal range 2..65535.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock (board reference clock after the differential buffer); all logic on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset (board power-on).
REQ-005 SHALL have port btn_reset_i, input, 1 bit: asynchronous, active-high, bouncing push-button reset request.
REQ-006 SHALL have port jtag_trst_ni, input, 1 bit: asynchronous, active-low JTAG TRST reset request.
REQ-007 SHALL have port clk_locked_i, input, 1 bit: asynchronous clock-stable indication; 1 = stable.
REQ-008 SHALL have port rst_no, output, 1 bit: active-low reset to the SoC pad_reset_n.
REQ-009 SHALL have port rst_cause_o, output, 2 bits: last reset cause; 00 = power-on, 01 = button, 10 = JTAG, 11 = lock loss.
REQ-010 SHALL have port rst_events_o, output, 8 bits: count of reset requests taken from RUN.

Function
REQ-011 SHALL pass btn_reset_i, jtag_trst_ni and clk_locked_i through separate 2-flop synchronizers, all reset to 0 (btn_sync, trst_sync, lock_sync).
REQ-012 SHALL debounce btn_sync into btn_db with a 16-bit counter: counter increments while btn_sync != btn_db and clears when they are equal.
REQ-013 SHALL toggle btn_db and clear the debounce counter at the edge where btn_sync != btn_db and the counter equals DEBOUNCE_CYCLES-1.
REQ-014 SHALL have no effect from a btn_sync pulse shorter than DEBOUNCE_CYCLES cycles.
REQ-015 SHALL define the reset request req = btn_db | ~trst_sync | ~lock_sync.
REQ-016 SHALL implement an FSM with states RESET, WAIT_LOCK, HOLD and RUN, resetting to RESET.
REQ-017 SHALL move RESET -> WAIT_LOCK unconditionally after one cycle.
REQ-018 SHALL move WAIT_LOCK -> HOLD when req = 0, clearing the 16-bit hold counter; otherwise it stays in WAIT_LOCK.
REQ-019 SHALL, in HOLD with req = 1, go to WAIT_LOCK and clear the hold counter.
REQ-020 SHALL, in HOLD with req = 0 and hold counter = HOLD_CYCLES-1, go to RUN.
REQ-021 SHALL, in HOLD otherwise, increment the hold counter.
REQ-022 SHALL, in RUN with req = 1, go to WAIT_LOCK.
REQ-023 SHALL drive rst_no from a dedicated flop loaded with (next_state == RUN), so it is glitch-free and high exactly while state == RUN.
REQ-024 SHALL, on RUN -> WAIT_LOCK, update rst_cause_o with priority JTAG (~trst_sync) > button (btn_db) > lock loss (~lock_sync) when causes coincide.
REQ-025 SHALL, on RUN -> WAIT_LOCK, increment rst_events_o, saturating at 255.
REQ-026 SHALL NOT change rst_cause_o or rst_events_o on requests seen in WAIT_LOCK or HOLD.
REQ-027 SHALL give a worst-case latency of 3 edges from request assertion at the input pin to rst_no low: 2 synchronizer edges plus 1 FSM edge (button additionally incurs the debounce delay).

Reset
REQ-028 SHALL force all outputs low on rst_ni low: rst_no = 0, rst_cause_o = 00, rst_events_o = 0.
REQ-029 SHALL force on rst_ni low: state = RESET, all counters 0, synchronizers 0, btn_db = 0.
REQ-030 SHALL assert rst_ni asynchronously and deassert it synchronously to clk_i inside the block.
REQ-031 SHALL abort the sequence immediately on rst_ni assertion mid-HOLD or mid-RUN, with no partial update of rst_cause_o or rst_events_o.

Verification
REQ-032 SHALL verify power-up: lock = 1, trst_n = 1, btn = 0 from time 0, then release rst_ni -> rst_no rises at rising edge 3+HOLD_CYCLES after release (259 with defaults), cause 00, events 0.
REQ-033 SHALL verify the bounce filter: in RUN, btn pulses of 1023 cycles separated by 1 low cycle, repeated 10 times -> rst_no stays 1 throughout.
REQ-034 SHALL verify a real press: in RUN, btn held high 2000 cycles -> rst_no falls 2+1024+1 edges after press, cause 01, events 1.
REQ-034 (cont.): after btn release, rst_no rises again after DEBOUNCE_CYCLES+HOLD_CYCLES+3 edges.
REQ-035 SHALL verify simultaneous causes: in RUN, trst_n low and lock low in the same cycle -> cause 10, events +1, rst_no low within 3 edges.
REQ-036 SHALL verify lock drop mid-HOLD: lock low at hold counter = 100 -> FSM returns to WAIT_LOCK, events unchanged; after lock returns, a full HOLD_CYCLES is re-counted.
REQ-037 SHALL verify saturation: 300 trst pulses of 10 cycles each, each issued from RUN -> rst_events_o = 255.
